// File: rtl/ysyx_23060203_inst_queue.sv
// Instruction queue between fetch and decode.
// A circular buffer of DEPTH entries. Each entry holds the fetched pc and inst
// plus class bits that are pre-decoded when the entry is pushed. A flush from
// the jump/CSR redirect path empties the queue at the next clock edge.
module ysyx_23060203_inst_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_is_branch,
    output logic        out_is_jal,
    output logic        out_is_jalr,
    output logic        out_pred_taken,
    output logic        out_fencei
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Opcode field inst[6:2] for the classes tracked here
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [2:0] F3_FENCEI   = 3'b001;

    // Queue control state
    logic [PW-1:0] hd_q, hd_d;
    logic [PW-1:0] tl_q, tl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Entry storage
    logic [31:0] pc_q     [DEPTH];
    logic [31:0] inst_q   [DEPTH];
    logic        branch_q [DEPTH];
    logic        jal_q    [DEPTH];
    logic        jalr_q   [DEPTH];
    logic        pred_q   [DEPTH];
    logic        fencei_q [DEPTH];

    // Handshake and pre-decode of the incoming word
    logic       push;
    logic       pop;
    logic [4:0] in_op;
    logic       in_branch;
    logic       in_jal;
    logic       in_jalr;
    logic       in_pred;
    logic       in_fencei;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0) & ~flush;

    // The flush cycle discards any push; out_valid is already gated by flush
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    // Pre-decode of the offered instruction, stored at push time
    always_comb begin
        in_op     = in_inst[6:2];
        in_branch = (in_op == OP_BRANCH);
        in_jal    = (in_op == OP_JAL);
        in_jalr   = (in_op == OP_JALR);
        in_pred   = in_branch & in_inst[31];
        in_fencei = (in_op == OP_MISC_MEM) & (in_inst[14:12] == F3_FENCEI);
    end

    // Next-state of pointers and occupancy
    always_comb begin
        hd_d  = hd_q;
        tl_d  = tl_q;
        cnt_d = cnt_q;
        if (flush) begin
            hd_d  = '0;
            tl_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                tl_d = tl_q + 1'b1;
            end
            if (pop) begin
                hd_d = hd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage: cleared on reset, written at the tail on push
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                inst_q[i]   <= '0;
                branch_q[i] <= 1'b0;
                jal_q[i]    <= 1'b0;
                jalr_q[i]   <= 1'b0;
                pred_q[i]   <= 1'b0;
                fencei_q[i] <= 1'b0;
            end
        end else if (push) begin
            pc_q[tl_q]     <= in_pc;
            inst_q[tl_q]   <= in_inst;
            branch_q[tl_q] <= in_branch;
            jal_q[tl_q]    <= in_jal;
            jalr_q[tl_q]   <= in_jalr;
            pred_q[tl_q]   <= in_pred;
            fencei_q[tl_q] <= in_fencei;
        end
    end

    // Head entry presented to decode; register indices re-sliced from inst
    always_comb begin
        out_pc         = pc_q[hd_q];
        out_inst       = inst_q[hd_q];
        out_rd         = inst_q[hd_q][11:7];
        out_rs1        = inst_q[hd_q][19:15];
        out_rs2        = inst_q[hd_q][24:20];
        out_is_branch  = branch_q[hd_q];
        out_is_jal     = jal_q[hd_q];
        out_is_jalr    = jalr_q[hd_q];
        out_pred_taken = pred_q[hd_q];
        out_fencei     = fencei_q[hd_q];
    end

endmodule

// File: tb/tb_ysyx_23060203_inst_queue.sv
// Self-checking bench for ysyx_23060203_inst_queue.
// Reference model: a plain FIFO of (pc, inst) pairs bounded at DEPTH; the
// expected class bits are derived from the stored inst using the ISA rules.
module tb_ysyx_23060203_inst_queue;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_is_branch;
    logic        out_is_jal;
    logic        out_is_jalr;
    logic        out_pred_taken;
    logic        out_fencei;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc[$];
    logic [31:0] m_inst[$];

    ysyx_23060203_inst_queue #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_is_branch  (out_is_branch),
        .out_is_jal     (out_is_jal),
        .out_is_jalr    (out_is_jalr),
        .out_pred_taken (out_pred_taken),
        .out_fencei     (out_fencei)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Class bits packed as {branch, jal, jalr, pred_taken, fencei}
    function automatic logic [4:0] classes(input logic [31:0] inst);
        logic [6:0] opcode;
        logic [2:0] f3;
        logic br, jl, jr, pt, fi;
        opcode = inst[6:0];
        f3     = inst[14:12];
        br = (opcode == 7'h63) || (opcode == 7'h60) || (opcode == 7'h61) || (opcode == 7'h62);
        br = (opcode[6:2] == 5'd24);
        jl = (opcode[6:2] == 5'd27);
        jr = (opcode[6:2] == 5'd25);
        pt = br && inst[31];
        fi = (opcode[6:2] == 5'd3) && (f3 == 3'd1);
        return {br, jl, jr, pt, fi};
    endfunction

    function automatic logic [4:0] obs_classes();
        return {out_is_branch, out_is_jal, out_is_jalr, out_pred_taken, out_fencei};
    endfunction

    task automatic check_head(input string tag);
        logic [31:0] ei;
        ei = m_inst[0];
        chk({tag, ".pc"},   out_pc,   m_pc[0]);
        chk({tag, ".inst"}, out_inst, ei);
        chk({tag, ".rd"},   32'(out_rd),  32'(ei[11:7]));
        chk({tag, ".rs1"},  32'(out_rs1), 32'(ei[19:15]));
        chk({tag, ".rs2"},  32'(out_rs2), 32'(ei[24:20]));
        chk({tag, ".cls"},  32'(obs_classes()), 32'(classes(ei)));
    endtask

    // One clock: drive inputs at the negedge, check, let the edge happen
    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic ordy, input logic fl);
        logic e_ready, e_valid;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        e_ready = (m_pc.size() != DEPTH);
        e_valid = (m_pc.size() != 0) && !fl;
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ready));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        if (m_pc.size() != 0) check_head(tag);
        if (fl) begin
            m_pc.delete();
            m_inst.delete();
        end else begin
            if (e_valid && ordy) begin
                void'(m_pc.pop_front());
                void'(m_inst.pop_front());
            end
            if (iv && e_ready) begin
                m_pc.push_back(pc);
                m_inst.push_back(inst);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_pc"},    out_pc,         32'd0);
        chk({tag, ".out_inst"},  out_inst,       32'd0);
        chk({tag, ".cls"},       32'(obs_classes()), 32'd0);
        chk({tag, ".regs"},      32'({out_rd, out_rs1, out_rs2}), 32'd0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'h63;
            1: r[6:0] = 7'h6F;
            2: r[6:0] = 7'h67;
            3: begin r[6:0] = 7'h0F; r[14:12] = 3'($urandom_range(0, 2)); end
            default: ;
        endcase
        return r;
    endfunction

    logic [31:0] pc;
    logic [31:0] exp_inst;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single push then visible next cycle
        step("push1", 1'b1, 32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0);
        chk("push1.out_rd",  32'(out_rd),  32'd1);
        chk("push1.out_rs1", 32'(out_rs1), 32'd0);
        chk("push1.out_pc",  out_pc,       32'h8000_0000);
        step("pop1", 1'b0, '0, '0, 1'b1, 1'b0);

        // Fill to full, refused 5th offer, then drain while offering
        for (int i = 0; i < 4; i++)
            step("fill", 1'b1, 32'h8000_0000 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        step("offer5", 1'b1, 32'h8000_0010, 32'h0000_0013, 1'b0, 1'b0);
        step("full_pop", 1'b1, 32'h8000_0010, 32'h0000_0013, 1'b1, 1'b0);
        chk("after_full_pop.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++)
            step("drain", 1'b0, '0, '0, 1'b1, 1'b0);

        // Streaming: 20 cycles of simultaneous push/pop
        pc = 32'h8000_0100;
        for (int i = 0; i < 20; i++) begin
            step("stream", 1'b1, pc, 32'h0000_0013, 1'b1, 1'b0);
            pc += 4;
        end
        step("stream_tail", 1'b0, '0, '0, 1'b1, 1'b0);

        // Pre-decode cases
        step("pd_beq_bwd", 1'b1, 32'h8000_0200, 32'hFE00_0EE3, 1'b0, 1'b0);
        chk("pd_beq_bwd.branch", 32'(out_is_branch),  32'd1);
        chk("pd_beq_bwd.pred",   32'(out_pred_taken), 32'd1);
        step("pd_pop", 1'b0, '0, '0, 1'b1, 1'b0);
        step("pd_beq_fwd", 1'b1, 32'h8000_0204, 32'h0000_0663, 1'b0, 1'b0);
        chk("pd_beq_fwd.pred", 32'(out_pred_taken), 32'd0);
        step("pd_pop", 1'b0, '0, '0, 1'b1, 1'b0);
        step("pd_fencei", 1'b1, 32'h8000_0208, 32'h0000_100F, 1'b0, 1'b0);
        chk("pd_fencei.fencei", 32'(out_fencei), 32'd1);
        step("pd_pop", 1'b0, '0, '0, 1'b1, 1'b0);
        step("pd_jalr", 1'b1, 32'h8000_020C, 32'h0000_80E7, 1'b0, 1'b0);
        chk("pd_jalr.jalr", 32'(out_is_jalr), 32'd1);
        chk("pd_jalr.rd",   32'(out_rd),      32'd1);
        chk("pd_jalr.rs1",  32'(out_rs1),     32'd1);
        step("pd_pop", 1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with 3 held entries and simultaneous push/pop
        for (int i = 0; i < 3; i++)
            step("pre_flush", 1'b1, 32'h8000_0300 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h8000_030C, 32'h0000_0013, 1'b1, 1'b1);
        step("post_flush", 1'b0, '0, '0, 1'b1, 1'b0);
        step("push_after_flush", 1'b1, 32'h8000_1000, 32'h0000_006F, 1'b0, 1'b0);
        chk("first_after_flush.pc", out_pc, 32'h8000_1000);
        step("pop_after_flush", 1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while empty with an offer: nothing stored
        step("flush_empty", 1'b1, 32'h8000_2000, 32'h0000_0013, 1'b0, 1'b1);
        step("after_flush_empty", 1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries held
        step("pre_rst", 1'b1, 32'h8000_3000, 32'hFE00_0EE3, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 32'h8000_3004, 32'h0000_80E7, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        m_pc.delete();
        m_inst.delete();
        #1;
        reset = 1'b0;
        @(negedge clock);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            exp_inst = rand_inst();
            step("rand", 1'($urandom_range(0, 3) != 0), $urandom, exp_inst,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
